// File: rtl/dmem_responder.sv
// Variable-latency data-memory responder for the memory stage: captures one
// load/store request, waits LATENCY cycles, performs the access and pulses a response.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid_ME,
  input  logic        ReqWrite_ME,
  input  logic [31:0] ReqAddr_ME,
  input  logic [31:0] ReqWrDat_ME,
  output logic        Stall_ME,
  output logic        RspValid_ME,
  output logic [31:0] RspRdDat_ME,
  output logic        RspErr_ME,
  output logic [15:0] AccessCnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = ADDR_WIDTH + 2;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cntNext;
  logic                  reqWrite;
  logic [BYTE_W-1:0]     reqAddr;
  logic [DATA_W-1:0]     reqWrDat;
  logic                  capture;
  logic                  memWe;
  logic                  rdLoad;
  logic                  enterResp;
  logic [ADDR_WIDTH-1:0] idx;

  logic [DATA_W-1:0] mem [DEPTH];

  // Address bits above the word index are deliberately dropped (wrap-around).
  logic unusedAddrBits;
  assign unusedAddrBits = ^ReqAddr_ME[31:BYTE_W];

  assign idx      = reqAddr[BYTE_W-1:2];
  assign Stall_ME = ReqValid_ME && (state != StResp);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StIdle;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state and access strobes
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    capture   = 1'b0;
    memWe     = 1'b0;
    rdLoad    = 1'b0;
    enterResp = 1'b0;
    case (state)
      StIdle: begin
        if (ReqValid_ME) begin
          capture   = 1'b1;
          cntNext   = CNT_W'(LATENCY);
          stateNext = StWait;
        end
      end
      StWait: begin
        if (cnt != '0) begin
          cntNext = cnt - CNT_W'(1);
        end else begin
          memWe     = reqWrite;
          rdLoad    = !reqWrite;
          enterResp = 1'b1;
          stateNext = StResp;
        end
      end
      StResp: stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
  end

  // Captured request and registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqWrite    <= 1'b0;
      reqAddr     <= '0;
      reqWrDat    <= '0;
      RspValid_ME <= 1'b0;
      RspErr_ME   <= 1'b0;
      RspRdDat_ME <= '0;
      AccessCnt   <= '0;
    end else begin
      if (capture) begin
        reqWrite <= ReqWrite_ME;
        reqAddr  <= ReqAddr_ME[BYTE_W-1:0];
        reqWrDat <= ReqWrDat_ME;
      end
      RspValid_ME <= enterResp;
      RspErr_ME   <= enterResp && (reqAddr[1:0] != 2'b00);
      if (rdLoad) begin
        RspRdDat_ME <= mem[idx];
      end
      if (enterResp && (AccessCnt != 16'hFFFF)) begin
        AccessCnt <= AccessCnt + 16'd1;
      end
    end
  end

  // Storage array is intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[idx] <= reqWrDat;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        reqValid [2];
  logic        reqWrite [2];
  logic [31:0] reqAddr  [2];
  logic [31:0] reqWrDat [2];
  logic        stall    [2];
  logic        rspValid [2];
  logic [31:0] rspRdDat [2];
  logic        rspErr   [2];
  logic [15:0] accessCnt[2];

  int nCmp = 0;
  int nBad = 0;

  dmem_responder #(.ADDR_WIDTH(6), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset),
    .ReqValid_ME(reqValid[0]), .ReqWrite_ME(reqWrite[0]),
    .ReqAddr_ME(reqAddr[0]), .ReqWrDat_ME(reqWrDat[0]),
    .Stall_ME(stall[0]), .RspValid_ME(rspValid[0]),
    .RspRdDat_ME(rspRdDat[0]), .RspErr_ME(rspErr[0]),
    .AccessCnt(accessCnt[0])
  );

  dmem_responder #(.ADDR_WIDTH(6), .LATENCY(0)) dut1 (
    .clk(clk), .reset(reset),
    .ReqValid_ME(reqValid[1]), .ReqWrite_ME(reqWrite[1]),
    .ReqAddr_ME(reqAddr[1]), .ReqWrDat_ME(reqWrDat[1]),
    .Stall_ME(stall[1]), .RspValid_ME(rspValid[1]),
    .RspRdDat_ME(rspRdDat[1]), .RspErr_ME(rspErr[1]),
    .AccessCnt(accessCnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request from a negedge, measures stall cycles and response cycle,
  // optionally changes the address at cycle chgAt, then drops the request.
  task automatic doAccess(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdat, input int lat, input int chgAt,
                          input logic [31:0] chgAddr, input string tag,
                          output logic [31:0] rdat, output logic err);
    int rspAt;
    int stallCnt;
    rspAt    = -1;
    stallCnt = 0;
    rdat     = '0;
    err      = 1'b0;
    reqWrite[d] = wr;
    reqAddr[d]  = addr;
    reqWrDat[d] = wdat;
    reqValid[d] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == chgAt) reqAddr[d] = chgAddr;
      #1;
      if (stall[d]) stallCnt++;
      if (rspValid[d]) begin
        rspAt = c;
        rdat  = rspRdDat[d];
        err   = rspErr[d];
        break;
      end
      @(negedge clk);
    end
    checkEq({tag, "_lat"}, 32'(rspAt), 32'(lat + 2));
    checkEq({tag, "_stall"}, 32'(stallCnt), 32'(lat + 2));
    @(negedge clk);
    reqValid[d] = 1'b0;
    #1;
    checkEq({tag, "_pulse"}, {31'd0, rspValid[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          seen;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      reqValid[d] = 1'b0;
      reqWrite[d] = 1'b0;
      reqAddr[d]  = '0;
      reqWrDat[d] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkEq("idle_stall", {31'd0, stall[0]}, 32'd0);
    checkEq("idle_rspvalid", {31'd0, rspValid[0]}, 32'd0);
    checkEq("idle_rddat", rspRdDat[0], 32'h0);
    checkEq("idle_cnt0", {16'd0, accessCnt[0]}, 32'd0);
    checkEq("idle_cnt1", {16'd0, accessCnt[1]}, 32'd0);
    @(negedge clk);

    // LATENCY=0: aligned store to word 4, then misaligned load of the same word
    doAccess(1, 1'b1, 32'h10, 32'hCAFEF00D, 0, -1, '0, "l0_st", rd, er);
    checkEq("l0_st_err", {31'd0, er}, 32'd0);
    doAccess(1, 1'b0, 32'h13, '0, 0, -1, '0, "l0_ld", rd, er);
    checkEq("l0_ld_data", rd, 32'hCAFEF00D);
    checkEq("l0_ld_err", {31'd0, er}, 32'd1);
    checkEq("l0_cnt", {16'd0, accessCnt[1]}, 32'd2);

    // LATENCY=2: store then back-to-back load of the same word
    doAccess(0, 1'b1, 32'h10, 32'hDEADBEEF, 2, -1, '0, "st10", rd, er);
    checkEq("st10_err", {31'd0, er}, 32'd0);
    doAccess(0, 1'b0, 32'h10, '0, 2, -1, '0, "ld10", rd, er);
    checkEq("ld10_data", rd, 32'hDEADBEEF);
    checkEq("ld10_err", {31'd0, er}, 32'd0);
    checkEq("cnt_after2", {16'd0, accessCnt[0]}, 32'd2);

    // Address wrap: 0x100 aliases word 0 with 6 index bits
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    doAccess(0, 1'b1, 32'h100, 32'h1234, 2, -1, '0, "st100", rd, er);
    doAccess(0, 1'b0, 32'h0, '0, 2, -1, '0, "ld0", rd, er);
    checkEq("wrap_data", rd, 32'h1234);
    checkEq("wrap_cnt", {16'd0, accessCnt[0]}, 32'd2);

    doAccess(0, 1'b1, 32'h8, 32'h55, 2, -1, '0, "st8", rd, er);
    doAccess(0, 1'b1, 32'h4, 32'h11111111, 2, -1, '0, "st4", rd, er);

    // Reset during the wait of a store: the write must be dropped
    reqWrite[0] = 1'b1;
    reqAddr[0]  = 32'h8;
    reqWrDat[0] = 32'hAA;
    reqValid[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    reqValid[0] = 1'b0;
    #1;
    checkEq("rst_rspvalid", {31'd0, rspValid[0]}, 32'd0);
    checkEq("rst_cnt", {16'd0, accessCnt[0]}, 32'd0);
    checkEq("rst_stall", {31'd0, stall[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (rspValid[0]) seen++;
      @(negedge clk);
    end
    checkEq("rst_no_rsp", 32'(seen), 32'd0);
    doAccess(0, 1'b0, 32'h8, '0, 2, -1, '0, "ld8", rd, er);
    checkEq("rst_ld8_data", rd, 32'h55);
    checkEq("rst_ld8_cnt", {16'd0, accessCnt[0]}, 32'd1);

    // Field changes after capture are ignored
    doAccess(0, 1'b0, 32'h4, '0, 2, 1, 32'h8, "chg_ld", rd, er);
    checkEq("chg_ld_data", rd, 32'h11111111);
    doAccess(0, 1'b1, 32'h4, 32'h77, 2, 1, 32'h8, "chg_st", rd, er);
    doAccess(0, 1'b0, 32'h8, '0, 2, -1, '0, "chk8", rd, er);
    checkEq("chg_st_w8", rd, 32'h55);
    doAccess(0, 1'b0, 32'h4, '0, 2, -1, '0, "chk4", rd, er);
    checkEq("chg_st_w4", rd, 32'h77);
    checkEq("final_cnt", {16'd0, accessCnt[0]}, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
